// File: rtl/acc_fp16.sv
`default_nettype none
// ============================================================================
// Module      : acc_fp16
// Description : Sequential fp16 accumulator. Adds a stream of products to a
//               per-vector bias with a 4-cycle align/add/normalize adder and
//               hands the final sum downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_fp16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  // Sentinel codes shared with the multiplier; they are not numeric values.
  localparam logic [15:0] POS_INF = 16'h7A00;
  localparam logic [15:0] NEG_INF = 16'hFA00;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  // Raw operands kept unswapped so the special cases can see which one is acc.
  logic [15:0]        a_raw_q, a_raw_d;
  logic [15:0]        b_raw_q, b_raw_d;
  logic               a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic [4:0]         a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [13:0]        a_man_q, a_man_d, b_man_q, b_man_d;
  logic [14:0]        sum_q, sum_d;
  logic               res_sign_q, res_sign_d;
  logic signed [6:0]  res_exp_q, res_exp_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // Combinational helpers
  logic [15:0]        a_src;
  logic               b_bigger;
  logic [13:0]        small_man;
  logic [4:0]         exp_diff;
  logic [3:0]         lzc;
  logic               found;
  logic [9:0]         norm_frac;
  logic signed [6:0]  norm_exp;
  logic [15:0]        norm_res;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

  function automatic logic is_inf(input logic [15:0] x);
    return (x == POS_INF) || (x == NEG_INF);
  endfunction

  // Normalize the registered sum and resolve the special cases into a result.
  always_comb begin
    lzc   = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lzc   = 4'(13 - i);
        found = 1'b1;
      end
    end
    if (sum_q[14]) begin
      norm_frac = sum_q[13:4];
      norm_exp  = res_exp_q + 7'sd1;
    end else begin
      norm_frac = 10'((sum_q[13:0] << lzc) >> 3);
      norm_exp  = res_exp_q - $signed({3'b000, lzc});
    end
    if (is_inf(a_raw_q)) begin
      norm_res = a_raw_q;
    end else if (is_inf(b_raw_q)) begin
      norm_res = b_raw_q;
    end else if (a_raw_q[14:10] == 5'd0) begin
      norm_res = b_raw_q;
    end else if (b_raw_q[14:10] == 5'd0) begin
      norm_res = a_raw_q;
    end else if (sum_q == 15'd0) begin
      norm_res = 16'h0000;
    end else if (norm_exp <= 7'sd0) begin
      norm_res = 16'h0000;
    end else if (norm_exp >= 7'sd31) begin
      norm_res = res_sign_q ? NEG_INF : POS_INF;
    end else begin
      norm_res = {res_sign_q, norm_exp[4:0], norm_frac};
    end
  end

  // Next-state logic for the FSM and the adder pipeline registers.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    first_d     = first_q;
    last_d      = last_q;
    a_raw_d     = a_raw_q;
    b_raw_d     = b_raw_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    a_exp_d     = a_exp_q;
    b_exp_d     = b_exp_q;
    a_man_d     = a_man_q;
    b_man_d     = b_man_q;
    sum_d       = sum_q;
    res_sign_d  = res_sign_q;
    res_exp_d   = res_exp_q;
    a_src       = first_q ? bias : acc_q;
    b_bigger    = (b_exp_q > a_exp_q) || ((b_exp_q == a_exp_q) && (b_man_q > a_man_q));
    small_man   = b_man_q;
    exp_diff    = 5'd0;

    case (state_q)
      S_WAIT: begin
        if (in_valid) begin
          a_raw_d  = a_src;
          b_raw_d  = in_data;
          last_d   = in_last;
          a_sign_d = a_src[15];
          a_exp_d  = a_src[14:10];
          a_man_d  = (a_src[14:10] == 5'd0) ? 14'd0 : {1'b1, a_src[9:0], 3'b000};
          b_sign_d = in_data[15];
          b_exp_d  = in_data[14:10];
          b_man_d  = (in_data[14:10] == 5'd0) ? 14'd0 : {1'b1, in_data[9:0], 3'b000};
          state_d  = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Larger magnitude becomes A; the smaller one is shifted into place.
        if (b_bigger) begin
          a_sign_d  = b_sign_q;
          a_exp_d   = b_exp_q;
          a_man_d   = b_man_q;
          b_sign_d  = a_sign_q;
          b_exp_d   = a_exp_q;
          small_man = a_man_q;
        end
        exp_diff = a_exp_d - b_exp_d;
        b_man_d  = (exp_diff >= 5'd14) ? 14'd0 : (small_man >> exp_diff);
        state_d  = S_ADD;
      end
      S_ADD: begin
        // A holds the larger magnitude, so the difference cannot go negative.
        if (a_sign_q == b_sign_q) begin
          sum_d = {1'b0, a_man_q} + {1'b0, b_man_q};
        end else begin
          sum_d = {1'b0, a_man_q} - {1'b0, b_man_q};
        end
        res_sign_d = a_sign_q;
        res_exp_d  = $signed({2'b00, a_exp_q});
        state_d    = S_NORM;
      end
      S_NORM: begin
        acc_d   = norm_res;
        first_d = 1'b0;
        state_d = last_q ? S_OUT : S_WAIT;
      end
      S_OUT: begin
        if (out_ready) begin
          first_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase

    in_ready_d  = (state_d == S_WAIT);
    out_valid_d = (state_d == S_OUT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT;
      acc_q       <= 16'h0000;
      first_q     <= 1'b1;
      last_q      <= 1'b0;
      a_raw_q     <= 16'h0000;
      b_raw_q     <= 16'h0000;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      a_exp_q     <= 5'd0;
      b_exp_q     <= 5'd0;
      a_man_q     <= 14'd0;
      b_man_q     <= 14'd0;
      sum_q       <= 15'd0;
      res_sign_q  <= 1'b0;
      res_exp_q   <= 7'sd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      last_q      <= last_d;
      a_raw_q     <= a_raw_d;
      b_raw_q     <= b_raw_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      a_exp_q     <= a_exp_d;
      b_exp_q     <= b_exp_d;
      a_man_q     <= a_man_d;
      b_man_q     <= b_man_d;
      sum_q       <= sum_d;
      res_sign_q  <= res_sign_d;
      res_exp_q   <= res_exp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_fp16.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_fp16
// Description : Self-checking bench for acc_fp16: directed vector table,
//               timing/backpressure/reset sequences and randomized vectors
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_fp16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string             name;
    logic [15:0]       bias;
    logic [3:0][15:0]  beats;
    int                n;
    logic [15:0]       exp_v;
  } vec_t;

  vec_t tbl[14];

  acc_fp16 dut (
    .clk       (clk),
    .rst       (rst),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  function automatic bit is_inf(input logic [15:0] x);
    return (x == 16'h7A00) || (x == 16'hFA00);
  endfunction

  // Reference: real-valued magnitudes on a 2^-13 mantissa grid, truncated.
  function automatic logic [15:0] model_add(input logic [15:0] acc_op, input logic [15:0] prod);
    int ea, eb, ma, mb, e_big, m_big, m_sml, d, s, e;
    bit sa, sb, s_big, s_sml;
    if (is_inf(acc_op)) return acc_op;
    if (is_inf(prod)) return prod;
    if (acc_op[14:10] == 5'd0) return prod;
    if (prod[14:10] == 5'd0) return acc_op;
    ea = int'(acc_op[14:10]); ma = (1024 + int'(acc_op[9:0])) * 8; sa = acc_op[15];
    eb = int'(prod[14:10]);   mb = (1024 + int'(prod[9:0])) * 8;   sb = prod[15];
    if (eb > ea || (eb == ea && mb > ma)) begin
      e_big = eb; m_big = mb; s_big = sb; m_sml = ma; s_sml = sa; d = eb - ea;
    end else begin
      e_big = ea; m_big = ma; s_big = sa; m_sml = mb; s_sml = sb; d = ea - eb;
    end
    if (d >= 14) m_sml = 0;
    else         m_sml = m_sml / (1 << d);
    s = (s_big == s_sml) ? (m_big + m_sml) : (m_big - m_sml);
    if (s == 0) return 16'h0000;
    e = e_big;
    while (s >= 16384) begin s = s / 2; e++; end
    while (s < 8192)   begin s = s * 2; e--; end
    if (e <= 0)  return 16'h0000;
    if (e >= 31) return s_big ? 16'hFA00 : 16'h7A00;
    return {s_big, 5'(e), 10'((s / 8) % 1024)};
  endfunction

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 11))
      0:       return 16'h7A00;
      1:       return 16'hFA00;
      2:       return {1'($urandom), 5'd0, 10'($urandom)};
      3:       return 16'($urandom);
      default: return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
    endcase
  endfunction

  function automatic vec_t mk(input string nm, input logic [15:0] b, input logic [15:0] x0,
                              input logic [15:0] x1, input logic [15:0] x2, input int n,
                              input logic [15:0] e);
    vec_t v;
    v.name  = nm;
    v.bias  = b;
    v.beats = {16'h0000, x2, x1, x0};
    v.n     = n;
    v.exp_v = e;
    return v;
  endfunction

  // Offers one beat; while the DUT is busy, drives junk that must be ignored.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int cnt = 0;
    while (!in_ready && cnt < 40) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      tick();
      cnt++;
    end
    check1("beat_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic run_vector(input string name, input logic [15:0] b, input logic [3:0][15:0] bt,
                            input int n, input logic [15:0] exp_v, input logic rdy);
    int cnt;
    bias      = b;
    out_ready = rdy;
    for (int i = 0; i < n; i++) begin
      send_beat(bt[i], (i == n - 1));
      if (i == 0) bias = 16'($urandom);
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check1({name, "_valid"}, out_valid, 1'b1);
    check16(name, out_data, exp_v);
    if (!rdy) begin
      repeat ($urandom_range(1, 3)) tick();
      check1({name, "_hold_valid"}, out_valid, 1'b1);
      check16({name, "_hold_data"}, out_data, exp_v);
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b1;
  endtask

  initial begin
    int lat;
    logic seen;

    rst       = 1'b1;
    bias      = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;

    tbl[0]  = mk("basic",      16'h0000, 16'h3C00, 16'h4000, 16'h0000, 2, 16'h4200);
    tbl[1]  = mk("cancel",     16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 1, 16'h0000);
    tbl[2]  = mk("zero_flush", 16'h4000, 16'h0123, 16'h0000, 16'h0000, 1, 16'h4000);
    tbl[3]  = mk("prec_lsb",   16'h3C00, 16'h1400, 16'h0000, 16'h0000, 1, 16'h3C01);
    tbl[4]  = mk("prec_trunc", 16'h3C00, 16'h0C00, 16'h0000, 16'h0000, 1, 16'h3C00);
    tbl[5]  = mk("overflow",   16'h7800, 16'h7800, 16'h0000, 16'h0000, 1, 16'h7A00);
    tbl[6]  = mk("inf_sticky", 16'hFA00, 16'h7A00, 16'h0000, 16'h0000, 1, 16'hFA00);
    tbl[7]  = mk("b_inf",      16'h3C00, 16'h7A00, 16'h0000, 16'h0000, 1, 16'h7A00);
    tbl[8]  = mk("sub_norm",   16'hC000, 16'h3C00, 16'h0000, 16'h0000, 1, 16'hBC00);
    tbl[9]  = mk("underflow",  16'h0600, 16'h8400, 16'h0000, 16'h0000, 1, 16'h0000);
    tbl[10] = mk("three_beat", 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 3, 16'h4500);
    tbl[11] = mk("bias_inf",   16'h7A00, 16'h3C00, 16'h0000, 16'h0000, 1, 16'h7A00);
    tbl[12] = mk("zero_bias",  16'h0000, 16'hC200, 16'h0000, 16'h0000, 1, 16'hC200);
    tbl[13] = mk("neg_ovf",    16'hF800, 16'hF800, 16'h0000, 16'h0000, 1, 16'hFA00);

    // Reset state
    tick();
    tick();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_out_data", out_data, 16'h0000);
    rst = 1'b0;

    // Basic sum with latency and in_ready timing
    bias     = 16'h0000;
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check1("busy_in_ready", in_ready, 1'b0);
      tick();
    end
    check1("ready_again", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check16("latency", 16'(lat), 16'd4);
    check16("basic_seq_data", out_data, 16'h4200);
    check1("out_in_ready", in_ready, 1'b0);
    tick();
    check1("pulse_valid_low", out_valid, 1'b0);
    check1("pulse_in_ready", in_ready, 1'b1);

    // Directed table
    for (int t = 0; t < 14; t++) begin
      run_vector(tbl[t].name, tbl[t].bias, tbl[t].beats, tbl[t].n, tbl[t].exp_v, 1'b1);
    end

    // Backpressure: hold out_ready low for 5 cycles
    bias      = 16'h4000;
    out_ready = 1'b0;
    send_beat(16'h3C00, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      check1("bp_valid", out_valid, 1'b1);
      check16("bp_data", out_data, 16'h4200);
      check1("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    check1("bp_valid_last", out_valid, 1'b1);
    tick();
    check1("bp_released", out_valid, 1'b0);
    run_vector("after_bp", 16'h3C00, {16'h0, 16'h0, 16'h0, 16'h3C00}, 1, 16'h4000, 1'b1);

    // Reset mid-vector after 2 of 3 beats
    bias = 16'h3C00;
    send_beat(16'h3C00, 1'b0);
    send_beat(16'h4000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("midrst_in_ready", in_ready, 1'b1);
    check1("midrst_out_valid", out_valid, 1'b0);
    check16("midrst_out_data", out_data, 16'h0000);
    seen = 1'b0;
    repeat (8) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check1("midrst_no_output", seen, 1'b0);
    run_vector("after_rst", 16'h4000, {16'h0, 16'h0, 16'h0, 16'h4000}, 1, 16'h4400, 1'b1);

    // Randomized vectors against the reference model
    for (int v = 0; v < 150; v++) begin
      logic [15:0]      b;
      logic [15:0]      m;
      logic [3:0][15:0] bt;
      int               n;
      b  = rand_val();
      n  = $urandom_range(1, 4);
      bt = '0;
      m  = b;
      for (int i = 0; i < n; i++) begin
        bt[i] = rand_val();
        m     = model_add(m, bt[i]);
      end
      run_vector("rand", b, bt, n, m, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
